// File: rtl/board_grid.sv
// -----------------------------------------------------------------------------
// board_grid
//   Parametrised N x N turn-based game board for P players. It stores the
//   owner of each cell, rotates the turn, refuses illegal moves and detects
//   row, column and diagonal wins as well as full-board draws.
//
//   Parameters
//     N  board dimension (2..8)
//     P  number of players (2..7)
//   Derived widths: RW = $clog2(N) coordinate bits, PW = $clog2(P+1) owner bits.
//
//   Ports
//     clock      system clock, rising edge
//     reset      asynchronous active-high clear
//     row, col   move target coordinates
//     select     move key (level); one request per rising edge
//     new_game   synchronous clear, same effect as reset
//     undo       take back the last move (only with BOARD_UNDO_EN)
//     cells      owner of cell (r,c) at [(r*N+c)*PW +: PW], 0 = empty
//     turn       player to move, 1..P
//     accept     one-cycle pulse: move (or undo) applied
//     reject     one-cycle pulse: request refused
//     game_over  high once a win or draw has been found
//     winner     winning player, 0 if none or draw
//     draw       board full without a winner
//
//   Optional feature macro: BOARD_UNDO_EN (one-deep undo history).
//
//   Pipeline: a request edge is registered together with row/col, then
//   acted upon one cycle later; the following CHECK cycle evaluates the
//   registered board.
// -----------------------------------------------------------------------------
module board_grid #(
  parameter  int N  = 3,
  parameter  int P  = 2,
  localparam int RW = $clog2(N),
  localparam int PW = $clog2(P + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [RW-1:0]       row,
  input  logic [RW-1:0]       col,
  input  logic                select,
  input  logic                new_game,
`ifdef BOARD_UNDO_EN
  input  logic                undo,
`endif
  output logic [N*N*PW-1:0]   cells,
  output logic [PW-1:0]       turn,
  output logic                accept,
  output logic                reject,
  output logic                game_over,
  output logic [PW-1:0]       winner,
  output logic                draw
);

  localparam int NC = N * N;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   board [NC];

  // Request front end
  logic            sel_q;
  logic            req_q;
  logic [RW-1:0]   row_q, col_q;

  // Move decode
  logic            in_range;
  logic            target_empty;
  logic [IW-1:0]   move_idx;

  // Board evaluation
  logic [PW-1:0]   win_owner;
  logic            board_full;

  // FSM decisions
  logic            write_move;
  logic            advance;
  logic            set_win;
  logic            set_draw;
  logic            accept_d;
  logic            reject_d;

`ifdef BOARD_UNDO_EN
  logic            undo_q;
  logic            undo_req_q;
  logic            undo_go;
  logic [IW-1:0]   hist_idx;
  logic [PW-1:0]   hist_turn;
  logic            hist_valid;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection and request capture. new_game re-arms the detector from
  // the live key level so a key held through the clear does not fire.
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_q      <= 1'b0;
      req_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
`ifdef BOARD_UNDO_EN
      undo_q     <= 1'b0;
      undo_req_q <= 1'b0;
`endif
    end else if (new_game) begin
      sel_q      <= select;
      req_q      <= 1'b0;
      row_q      <= row;
      col_q      <= col;
`ifdef BOARD_UNDO_EN
      undo_q     <= undo;
      undo_req_q <= 1'b0;
`endif
    end else begin
      sel_q      <= select;
      req_q      <= select & ~sel_q;
      row_q      <= row;
      col_q      <= col;
`ifdef BOARD_UNDO_EN
      undo_q     <= undo;
      undo_req_q <= undo & ~undo_q;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Move target decode. The index is only meaningful when in range, so the
  // occupancy lookup is guarded by the range test.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_range     = (int'(row_q) < N) && (int'(col_q) < N);
    move_idx     = IW'(int'(row_q) * N + int'(col_q));
    target_empty = in_range ? (board[move_idx] == '0) : 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Win / full detection over the registered board. A line counts only when
  // all its cells match a nonzero owner.
  // ---------------------------------------------------------------------------
  always_comb begin : win_eval
    logic [PW-1:0] first;
    logic          same;
    // NOTE: every variable written here gets a default first, so no path
    // can leave it holding a value and infer a latch.
    first      = '0;
    same       = 1'b0;
    win_owner  = '0;
    board_full = 1'b1;

    for (int i = 0; i < NC; i++)
      if (board[i] == '0) board_full = 1'b0;

    for (int r = 0; r < N; r++) begin
      first = board[r*N];
      same  = 1'b1;
      for (int c = 0; c < N; c++)
        if (board[r*N+c] != first) same = 1'b0;
      if (same && first != '0) win_owner = first;
    end

    for (int c = 0; c < N; c++) begin
      first = board[c];
      same  = 1'b1;
      for (int r = 0; r < N; r++)
        if (board[r*N+c] != first) same = 1'b0;
      if (same && first != '0) win_owner = first;
    end

    first = board[0];
    same  = 1'b1;
    for (int i = 0; i < N; i++)
      if (board[i*N+i] != first) same = 1'b0;
    if (same && first != '0) win_owner = first;

    first = board[N-1];
    same  = 1'b1;
    for (int i = 0; i < N; i++)
      if (board[i*N+(N-1-i)] != first) same = 1'b0;
    if (same && first != '0) win_owner = first;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         state <= PLAY;
    else if (new_game) state <= PLAY;
    else               state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    write_move = 1'b0;
    advance    = 1'b0;
    set_win    = 1'b0;
    set_draw   = 1'b0;
    accept_d   = 1'b0;
    reject_d   = 1'b0;
`ifdef BOARD_UNDO_EN
    undo_go    = 1'b0;
`endif

    unique case (state)
      PLAY: begin
        if (req_q) begin
          if (target_empty) begin
            write_move = 1'b1;
            accept_d   = 1'b1;
            state_next = CHECK;
          end else begin
            reject_d   = 1'b1;
          end
        end
      end
      CHECK: begin
        // Requests are not queued behind the evaluation cycle.
        reject_d = req_q;
        if (win_owner != '0) begin
          set_win    = 1'b1;
          state_next = OVER;
        end else if (board_full) begin
          set_draw   = 1'b1;
          state_next = OVER;
        end else begin
          advance    = 1'b1;
          state_next = PLAY;
        end
      end
      OVER: begin
        reject_d = req_q;
      end
      default: state_next = PLAY;
    endcase

`ifdef BOARD_UNDO_EN
    // Undo outranks a simultaneous move; the move is then refused.
    if (undo_req_q) begin
      if (state == CHECK) begin
        reject_d = 1'b1;
      end else begin
        write_move = 1'b0;
        undo_go    = hist_valid;
        accept_d   = hist_valid;
        reject_d   = req_q | ~hist_valid;
        state_next = hist_valid ? PLAY : state;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Board, turn, result flags and history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the board array is cleared on reset because the renderer and
      // the win logic read it directly; it must never start unknown.
      for (int i = 0; i < NC; i++) board[i] <= '0;
      turn       <= PW'(1);
      winner     <= '0;
      draw       <= 1'b0;
      accept     <= 1'b0;
      reject     <= 1'b0;
`ifdef BOARD_UNDO_EN
      hist_idx   <= '0;
      hist_turn  <= '0;
      hist_valid <= 1'b0;
`endif
    end else if (new_game) begin
      for (int i = 0; i < NC; i++) board[i] <= '0;
      turn       <= PW'(1);
      winner     <= '0;
      draw       <= 1'b0;
      accept     <= 1'b0;
      reject     <= 1'b0;
`ifdef BOARD_UNDO_EN
      hist_valid <= 1'b0;
`endif
    end else begin
      accept <= accept_d;
      reject <= reject_d;
      if (write_move) begin
        board[move_idx] <= turn;
`ifdef BOARD_UNDO_EN
        hist_idx   <= move_idx;
        hist_turn  <= turn;
        hist_valid <= 1'b1;
`endif
      end
      if (advance)  turn   <= (turn == PW'(P)) ? PW'(1) : turn + PW'(1);
      if (set_win)  winner <= win_owner;
      if (set_draw) draw   <= 1'b1;
`ifdef BOARD_UNDO_EN
      if (undo_go) begin
        board[hist_idx] <= '0;
        turn            <= hist_turn;
        winner          <= '0;
        draw            <= 1'b0;
        hist_valid      <= 1'b0;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cells = '0;
    for (int i = 0; i < NC; i++) cells[i*PW +: PW] = board[i];
  end

  assign game_over = (state == OVER);

endmodule
